// File: rtl/icache_mshr_entry_ctrl.sv
// Purpose : control FSM for one I-cache MSHR entry. It takes an allocation, waits out
//           older same-set dependencies, then issues a cache read (hit) or a
//           downstream line fetch (miss), waits for the fill and retires the entry.
// Latency : allocation to rd_vld/ds_vld takes 1 cycle when there is no dependency.
//           Handshake to entry_done takes 1 cycle on the read path. On the miss
//           path entry_done follows fill_done by 1 cycle.
// Backpressure: rd_vld and ds_vld hold with a stable payload until rd_rdy or ds_rdy.
//           alloc_rdy is high only while the entry is IDLE.
// Ports   : clk/rst (async, active-high); alloc_* allocation request; dep_live holds the
//           live valid bits of all entries; rd_* cache read request; ds_* downstream
//           request; fill_done marks fill completion; entry_busy/done/timeout give status.
// Option  : defining ICACHE_MSHR_TIMEOUT_EN adds a fill watchdog. After TIMEOUT_CYC
//           WAIT_FILL cycles it pulses entry_timeout and reissues the downstream request.
module icache_mshr_entry_ctrl #(
  parameter int WAY_NUM     = 4,
  parameter int ENTRY_NUM   = 8,
  parameter int INDEX_W     = 7,
  parameter int TXNID_W     = 5,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_vld,
  output logic                       alloc_rdy,
  input  logic [1:0]                 alloc_op,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic [TXNID_W-1:0]         alloc_txnid,
  input  logic [$clog2(WAY_NUM)-1:0] alloc_way,
  input  logic                       alloc_hit,
  input  logic [ENTRY_NUM-1:0]       alloc_dep,
  input  logic [ENTRY_NUM-1:0]       dep_live,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [INDEX_W-1:0]         rd_index,
  output logic [$clog2(WAY_NUM)-1:0] rd_way,
  output logic [TXNID_W-1:0]         rd_txnid,
  output logic                       ds_vld,
  input  logic                       ds_rdy,
  output logic [ADDR_W-1:0]          ds_addr,
  output logic [TXNID_W-1:0]         ds_txnid,
  input  logic                       fill_done,
  output logic                       entry_busy,
  output logic                       entry_done,
  output logic                       entry_timeout
);

  localparam int WAY_W  = $clog2(WAY_NUM);
  localparam int LINE_W = ADDR_W - 6;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DEP  = 3'd1;
  localparam logic [2:0] S_RD_REQ    = 3'd2;
  localparam logic [2:0] S_DS_REQ    = 3'd3;
  localparam logic [2:0] S_WAIT_FILL = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [1:0] OP_UP = 2'd0;
  localparam logic [1:0] OP_DS = 2'd1;
  localparam logic [1:0] OP_PF = 2'd2;

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [LINE_W-1:0]    line_q, line_d;      // the byte offset is never needed
  logic [TXNID_W-1:0]   txnid_q, txnid_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic                 hit_q, hit_d;
  logic [ENTRY_NUM-1:0] dep_keep_q, dep_keep_d;
  logic                 rd_path;
  logic                 tout_fire;

  // Byte-offset bits of the allocation address are intentionally dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^alloc_addr[5:0];

  // Only an upstream hit reads the array; every other non-retiring case fetches.
  assign rd_path = hit_q && (op_q == OP_UP);

`ifdef ICACHE_MSHR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // fill_done on the expiry cycle takes priority, so no timeout fires then.
  assign tout_fire = (state_q == S_WAIT_FILL) && !fill_done && (cnt_q == TOUT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DS_REQ && ds_rdy) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT_FILL && !fill_done && !tout_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tout_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    line_d     = line_q;
    txnid_d    = txnid_q;
    way_d      = way_q;
    hit_d      = hit_q;
    // Once a dependency's entry drops valid it stays cleared. A later
    // reallocation of that slot is a younger request, not the one we wait on.
    dep_keep_d = (state_q == S_IDLE) ? dep_keep_q : (dep_keep_q & dep_live);

    case (state_q)
      S_IDLE: begin
        if (alloc_vld) begin
          op_d       = alloc_op;
          line_d     = alloc_addr[ADDR_W-1:6];
          txnid_d    = alloc_txnid;
          way_d      = alloc_way;
          hit_d      = alloc_hit;
          dep_keep_d = alloc_dep;
          if (alloc_op == OP_DS || (alloc_op == OP_PF && alloc_hit)) begin
            state_d = S_DONE;
          end else if ((alloc_dep & dep_live) != '0) begin
            state_d = S_WAIT_DEP;
          end else if (alloc_hit && alloc_op == OP_UP) begin
            state_d = S_RD_REQ;
          end else begin
            state_d = S_DS_REQ;
          end
        end
      end
      S_WAIT_DEP: begin
        if ((dep_keep_q & dep_live) == '0) begin
          state_d = rd_path ? S_RD_REQ : S_DS_REQ;
        end
      end
      S_RD_REQ: begin
        if (rd_rdy) state_d = S_DONE;
      end
      S_DS_REQ: begin
        if (ds_rdy) state_d = S_WAIT_FILL;
      end
      S_WAIT_FILL: begin
        if (fill_done) begin
          state_d = S_DONE;
        end else if (tout_fire) begin
          state_d = S_DS_REQ;             // reissue the identical request
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      line_q     <= '0;
      txnid_q    <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      dep_keep_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      line_q     <= line_d;
      txnid_q    <= txnid_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      dep_keep_q <= dep_keep_d;
    end
  end

  assign alloc_rdy     = (state_q == S_IDLE);
  assign entry_busy    = (state_q != S_IDLE);
  assign entry_done    = (state_q == S_DONE);
  assign entry_timeout = tout_fire;

  assign rd_vld   = (state_q == S_RD_REQ);
  assign rd_index = rd_vld ? line_q[INDEX_W-1:0] : '0;
  assign rd_way   = rd_vld ? way_q : '0;
  assign rd_txnid = rd_vld ? txnid_q : '0;

  assign ds_vld   = (state_q == S_DS_REQ);
  assign ds_addr  = ds_vld ? {line_q, 6'b0} : '0;
  assign ds_txnid = ds_vld ? txnid_q : '0;

endmodule

// File: tb/tb_icache_mshr_entry_ctrl.sv
module tb_icache_mshr_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_vld, alloc_rdy;
  logic [1:0]  alloc_op;
  logic [31:0] alloc_addr;
  logic [4:0]  alloc_txnid;
  logic [1:0]  alloc_way;
  logic        alloc_hit;
  logic [7:0]  alloc_dep, dep_live;
  logic        rd_vld, rd_rdy;
  logic [6:0]  rd_index;
  logic [1:0]  rd_way;
  logic [4:0]  rd_txnid;
  logic        ds_vld, ds_rdy;
  logic [31:0] ds_addr;
  logic [4:0]  ds_txnid;
  logic        fill_done, entry_busy, entry_done, entry_timeout;

`ifdef ICACHE_MSHR_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  icache_mshr_entry_ctrl #(.WAY_NUM(4), .ENTRY_NUM(8), .INDEX_W(7), .TXNID_W(5),
                           .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_op(alloc_op),
    .alloc_addr(alloc_addr), .alloc_txnid(alloc_txnid), .alloc_way(alloc_way),
    .alloc_hit(alloc_hit), .alloc_dep(alloc_dep), .dep_live(dep_live),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_index(rd_index), .rd_way(rd_way),
    .rd_txnid(rd_txnid), .ds_vld(ds_vld), .ds_rdy(ds_rdy), .ds_addr(ds_addr),
    .ds_txnid(ds_txnid), .fill_done(fill_done), .entry_busy(entry_busy),
    .entry_done(entry_done), .entry_timeout(entry_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_c  = 0;
  int obs_path;
  logic [6:0]  obs_idx;
  logic [31:0] obs_ds;

  typedef struct {
    logic [1:0]  op;
    logic        hit;
    logic [31:0] addr;
    logic [1:0]  way;
    logic [4:0]  txnid;
    int          exp_path;    // 0 retire only, 1 cache read, 2 downstream fetch
    logic [6:0]  exp_idx;
    logic [31:0] exp_ds;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s c=%0d act=%0h exp=%0h", name, cur_c, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_alloc_rdy"}, alloc_rdy, 1);
    chk({tag, "_busy"}, entry_busy, 0);
    chk({tag, "_done"}, entry_done, 0);
    chk({tag, "_tout"}, entry_timeout, 0);
    chk({tag, "_rd"}, {rd_vld, rd_index, rd_way, rd_txnid}, 0);
    chk({tag, "_ds"}, {ds_vld, ds_addr, ds_txnid}, 0);
  endtask

  task automatic set_quiet();
    alloc_vld = 0; alloc_op = 0; alloc_addr = 0; alloc_txnid = 0; alloc_way = 0;
    alloc_hit = 0; alloc_dep = 0; dep_live = 0; rd_rdy = 0; ds_rdy = 0; fill_done = 0;
  endtask

  // One allocation, checked every cycle against event times from the spec rules:
  // the dependency is live for cycles 0..k, rdy is low for s valid cycles, and
  // fill_done comes f cycles into WAIT_FILL. Entry to be called at posedge+1.
  task automatic run_txn(input logic [1:0] op, input logic hit, input logic [31:0] addr,
                         input logic [1:0] way, input logic [4:0] txnid, input logic [7:0] dep,
                         input int k, input bit rerise, input int s, input int f,
                         input bit stray, input logic [7:0] noise);
    int path, v, dn;
    bit blocked, e_rd, e_ds, fd;
    path    = (op == 1 || (op == 2 && hit)) ? 0 : (op == 0 && hit) ? 1 : 2;
    blocked = (dep != 0);
    v       = blocked ? k + 2 : 1;
    dn      = (path == 0) ? 1 : (path == 1) ? v + s + 1 : v + s + 2 + f;
    obs_path = 0; obs_idx = 0; obs_ds = 0;
    for (int c = 0; c <= dn + 1; c++) begin
      cur_c = c;
      // Allocation attempts while busy must be ignored.
      alloc_vld   = (c == 0) || (stray && c >= 1 && c <= dn);
      alloc_op    = (c == 0) ? op : 2'd1;
      alloc_addr  = (c == 0) ? addr : $urandom;
      alloc_txnid = (c == 0) ? txnid : 5'($urandom);
      alloc_way   = (c == 0) ? way : 2'($urandom);
      alloc_hit   = (c == 0) ? hit : 1'b1;
      alloc_dep   = dep;
      dep_live    = (noise & ~dep) |
                    ((blocked && (c <= k || (rerise && c > k + 1))) ? dep : 8'h00);
      rd_rdy      = (c >= v + s);
      ds_rdy      = (c >= v + s);
      fd          = (path == 2 && c == v + s + 1 + f);
      if (stray && (c % 2 == 1) && !(path == 2 && c >= v + s + 1 && c <= v + s + 1 + f))
        fd = 1;
      fill_done = fd;
      @(negedge clk);
      e_rd = (path == 1) && c >= v && c <= v + s;
      e_ds = (path == 2) && c >= v && c <= v + s;
      chk("alloc_rdy", alloc_rdy, (c == 0 || c > dn));
      chk("busy", entry_busy, (c >= 1 && c <= dn));
      chk("done", entry_done, (c == dn));
      chk("tout", entry_timeout, 0);
      chk("rd_vld", rd_vld, e_rd);
      chk("rd_pay", {rd_index, rd_way, rd_txnid}, e_rd ? {addr[12:6], way, txnid} : 14'h0);
      chk("ds_vld", ds_vld, e_ds);
      chk("ds_pay", {ds_addr, ds_txnid}, e_ds ? {addr[31:6], 6'h0, txnid} : 37'h0);
      if (rd_vld) begin obs_path = 1; obs_idx = rd_index; end
      if (ds_vld) begin obs_path = 2; obs_ds = ds_addr; end
      @(posedge clk); #1;
    end
    set_quiet();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 1'b1, 32'h0000_1240, 2'd2, 5'd5,  1, 7'h49, 32'h0};
    vecs[1] = '{2'd2, 1'b0, 32'h8000_007F, 2'd1, 5'd3,  2, 7'h00, 32'h8000_0040};
    vecs[2] = '{2'd1, 1'b1, 32'h1234_5678, 2'd3, 5'd9,  0, 7'h00, 32'h0};
    vecs[3] = '{2'd1, 1'b0, 32'hFFFF_FFFF, 2'd0, 5'd1,  0, 7'h00, 32'h0};
    vecs[4] = '{2'd2, 1'b1, 32'h0000_0FC0, 2'd1, 5'd2,  0, 7'h00, 32'h0};
    vecs[5] = '{2'd0, 1'b0, 32'hDEAD_BEEF, 2'd0, 5'd31, 2, 7'h00, 32'hDEAD_BEC0};
    vecs[6] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 2'd3, 5'd31, 1, 7'h7F, 32'h0};
    vecs[7] = '{2'd0, 1'b1, 32'h0000_003F, 2'd1, 5'd0,  1, 7'h00, 32'h0};

    set_quiet();
    rst = 1'b1;
    #12;
    cur_c = -1;
    chk_idle_outputs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with free-flowing handshakes.
    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].hit, vecs[i].addr, vecs[i].way, vecs[i].txnid,
              8'h00, 0, 0, 0, 2, 0, 8'h00);
      chk("vec_path", obs_path, vecs[i].exp_path);
      chk("vec_idx", obs_idx, vecs[i].exp_idx);
      chk("vec_dsaddr", obs_ds, vecs[i].exp_ds);
    end

    // Prefetch miss, downstream stalled for 3 cycles, fill 10 cycles later.
    run_txn(2'd2, 1'b0, 32'h8000_007F, 2'd1, 5'd3, 8'h00, 0, 0, 3, 9, 0, 8'h00);
    // Dependency on entry 2 live for 5 cycles, drops, then the slot is reused.
    run_txn(2'd0, 1'b0, 32'h0000_2000, 2'd0, 5'd7, 8'b0000_0100, 4, 1, 1, 3, 0, 8'hF0);
    // Blocked upstream hit with stray fill_done and ignored allocations.
    run_txn(2'd0, 1'b1, 32'h0000_3FC0, 2'd3, 5'd12, 8'b1000_0001, 2, 0, 2, 0, 1, 8'h00);

    // Randomized transactions.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] dep;
      dep = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      run_txn(2'($urandom_range(0, 2)), 1'($urandom), $urandom, 2'($urandom), 5'($urandom),
              dep, $urandom_range(0, 5), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 15), 1'($urandom), 8'($urandom));
    end

    // Lost fill: the watchdog reissues at the 16th WAIT_FILL cycle when built in.
    // Without it, the entry waits until the late fill arrives.
    for (int c = 0; c <= 36; c++) begin
      bit e_ds;
      cur_c = 100 + c;
      alloc_vld = (c == 0); alloc_op = 2'd2; alloc_hit = 1'b0;
      alloc_addr = 32'h1000_0085; alloc_txnid = 5'h11; alloc_way = 2'd1;
      ds_rdy = 1'b1; fill_done = (c == 34);
      @(negedge clk);
      e_ds = (c == 1) || (TEN && c == 18);
      chk("to_tout", entry_timeout, (TEN && c == 17));
      chk("to_ds_vld", ds_vld, e_ds);
      chk("to_ds_pay", {ds_addr, ds_txnid}, e_ds ? {32'h1000_0080, 5'h11} : 37'h0);
      chk("to_done", entry_done, (c == 35));
      @(posedge clk); #1;
    end
    set_quiet();

    // Reset in the middle of RD_REQ drops the request with no entry_done.
    alloc_vld = 1; alloc_op = 2'd0; alloc_hit = 1; alloc_addr = 32'h0000_1240;
    alloc_way = 2'd2; alloc_txnid = 5'd5;
    @(posedge clk); #1;
    set_quiet();
    cur_c = 200;
    chk("rst_pre_rd_vld", rd_vld, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cur_c = 201 + c;
      chk_idle_outputs("rst_after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog c=%0d act=running exp=finished", cur_c);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/icache_mshr_entry_ctrl.md
ICACHE_MSHR_ENTRY_CTRL -- requirements
Module: icache_mshr_entry_ctrl

Interface
REQ-001 SHALL have parameter WAY_NUM, default 4, number of cache ways, minimum 2.
REQ-002 SHALL have parameter ENTRY_NUM, default 8, MSHR depth and width of the dependency vectors.
REQ-003 SHALL have parameter INDEX_W, default 7; TXNID_W, default 5; ADDR_W, default 32; TIMEOUT_CYC, default 256.
REQ-004 SHALL have ports clk in 1 clock; rst in 1 reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have ports alloc_vld in 1; alloc_rdy out 1; alloc_op in 2 (0 upstream, 1 downstream, 2 prefetch); alloc_addr in ADDR_W; alloc_txnid in TXNID_W; alloc_way in clog2(WAY_NUM); alloc_hit in 1; alloc_dep in ENTRY_NUM (older entries on the same index/way).
REQ-006 SHALL have ports dep_live in ENTRY_NUM, live valid bits of all entries.
REQ-007 SHALL have ports rd_vld out 1; rd_rdy in 1; rd_index out INDEX_W; rd_way out clog2(WAY_NUM); rd_txnid out TXNID_W.
REQ-008 SHALL have ports ds_vld out 1; ds_rdy in 1; ds_addr out ADDR_W; ds_txnid out TXNID_W; fill_done in 1.
REQ-009 SHALL have ports entry_busy out 1; entry_done out 1; entry_timeout out 1.

Function
REQ-010 SHALL implement states IDLE, WAIT_DEP, RD_REQ, DS_REQ, WAIT_FILL, DONE.
REQ-011 SHALL set alloc_rdy = (state==IDLE) and accept an allocation when alloc_vld & alloc_rdy, registering op, addr, txnid, way, hit and dep_keep = alloc_dep.
REQ-012 SHALL, on acceptance, go to DONE for downstream op or for prefetch with hit, else WAIT_DEP if (alloc_dep & dep_live)!=0, else RD_REQ for upstream hit, DS_REQ for upstream/prefetch miss.
REQ-013 SHALL update dep_keep <= dep_keep & dep_live every non-IDLE cycle, so a dependency clears permanently once its entry drops valid, even if that entry is reallocated.
REQ-014 SHALL leave WAIT_DEP the cycle after (dep_keep & dep_live)==0, to RD_REQ on hit or DS_REQ on miss.
REQ-015 SHALL drive rd_vld=1 only in RD_REQ, with rd_index = addr[INDEX_W+5:6], rd_way and rd_txnid from registers, stable while rd_rdy=0; rd_vld & rd_rdy moves to DONE.
REQ-016 SHALL drive ds_vld=1 only in DS_REQ with ds_addr line-aligned (addr[5:0] zeroed) and ds_txnid held stable; ds_vld & ds_rdy moves to WAIT_FILL.
REQ-017 SHALL move WAIT_FILL to DONE on fill_done; fill_done in any other state SHALL be ignored.
REQ-018 SHALL stay in DONE exactly one cycle, pulse entry_done=1 there, then return to IDLE; a new allocation is accepted no earlier than the cycle after DONE.
REQ-019 SHALL set entry_busy = (state!=IDLE); minimum allocation-to-rd_vld latency is 1 cycle.
REQ-020 SHALL drive all payload outputs to zero when their valid is low.

Reset
REQ-021 SHALL on rst assertion immediately force state IDLE, clear all registers, including dep_keep and the timeout counter, and drive alloc_rdy=1 and every other output 0; an in-flight request is dropped without entry_done.

Configuration
REQ-022 SHALL, with ICACHE_MSHR_TIMEOUT_EN defined, count WAIT_FILL cycles from 0. The counter resets on entry to WAIT_FILL. When it reaches TIMEOUT_CYC-1 without fill_done, the block SHALL pulse entry_timeout for one cycle and return to DS_REQ to reissue the identical request. fill_done on the expiry cycle wins, with no timeout.
REQ-023 SHALL, without ICACHE_MSHR_TIMEOUT_EN, have no counter logic; entry_timeout is tied 0 and WAIT_FILL waits indefinitely.

Verification
REQ-024 Upstream hit, alloc_dep=0, rd_rdy=1: addr=0x0000_1240, way=2, txnid=5 -> rd_vld cycle+1 with rd_index=0x49, rd_way=2, rd_txnid=5; entry_done at cycle+2; alloc_rdy at cycle+3.
REQ-025 Prefetch miss, addr=0x8000_007F, ds_rdy low for 3 cycles -> ds_vld held 4 cycles with ds_addr=0x8000_0040. fill_done 10 cycles later -> entry_done the next cycle.
REQ-026 Upstream miss, alloc_dep=0b0000_0100, dep_live[2]=1 for 5 cycles, then 0, then 1 again -> DS_REQ entered after the first drop and not re-blocked by the second rise.
REQ-027 Downstream op with hit=1 -> neither rd_vld nor ds_vld asserted; entry_done at cycle+1.
REQ-028 With ICACHE_MSHR_TIMEOUT_EN and TIMEOUT_CYC=16, no fill_done -> entry_timeout pulse after 16 WAIT_FILL cycles and ds_vld reasserted with the same txnid. Also, rst asserted mid-RD_REQ -> outputs 0 and alloc_rdy=1 immediately.
